// File: rtl/pll_clken_gen.sv
// pll_clken_gen
//   Clock-enable generator that sits behind a PLL. It qualifies pll_locked,
//   sequences a clean downstream reset, and then drives NUM_CH independent
//   NCO clock-enable pulses on the fast PLL clock.
// Ports
//   refclk      in   fast PLL output clock (only clock)
//   rst_n       in   async active-low reset
//   pll_locked  in   PLL locked, asynchronous to refclk
//   ch_inc      in   per-channel phase increment, ch i at [i*ACC_W +: ACC_W]
//   ch_en       in   per-channel run enable
//   clken       out  one-refclk-wide enable pulses
//   sys_rst_n   out  sequenced active-low reset for downstream logic
//   running     out  1 while in RUN
//   lock_lost   out  sticky, lock dropped after RUN was reached

// One NCO channel. step is high only on edges where the FSM is in RUN and
// stays in RUN; any other edge clears the phase and the pulse.
module pll_clken_lane #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             clken
);
    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            clken <= 1'b0;
        end else if (!step) begin
            acc   <= '0;
            clken <= 1'b0;
        end else if (en) begin
            // carry out of the phase sum becomes the registered pulse
            {clken, acc} <= {1'b0, acc} + {1'b0, inc};
        end else begin
            // disabled: phase held so re-enable resumes where it stopped
            clken <= 1'b0;
        end
    end
endmodule

module pll_clken_gen #(
    parameter int NUM_CH      = 3,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 1024,
    parameter int RST_HOLD    = 16
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*ACC_W-1:0] ch_inc,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       clken,
    output logic                    sys_rst_n,
    output logic                    running,
    output logic                    lock_lost
);
    localparam int CNT_MAX = (LOCK_CYCLES > RST_HOLD) ? LOCK_CYCLES : RST_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, HOLD, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       lk_sync;
    logic             lk;
    logic             nco_step;

    // 2-flop synchroniser for the asynchronous lock indication
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) lk_sync <= 2'b00;
        else        lk_sync <= {lk_sync[0], pll_locked};
    end
    assign lk = lk_sync[1];

    // One counter serves both SETTLE and HOLD; it is zero on entry to each.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lk) state_d = SETTLE;
            end
            SETTLE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lk) state_d = WAIT_LOCK;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the state itself.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sys_rst_n <= 1'b0;
            running   <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            sys_rst_n <= (state_d == RUN);
            running   <= (state_d == RUN);
            lock_lost <= lock_lost | ((state_q == RUN) && !lk);
        end
    end

    // NCOs only advance on edges that stay in RUN; the exit edge clears them.
    assign nco_step = (state_q == RUN) && (state_d == RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pll_clken_lane #(.ACC_W(ACC_W)) u_lane (
            .clk   (refclk),
            .rst_n (rst_n),
            .step  (nco_step),
            .en    (ch_en[i]),
            .inc   (ch_inc[i*ACC_W +: ACC_W]),
            .clken (clken[i])
        );
    end
endmodule

// File: tb/tb_pll_clken_gen.sv
module tb_pll_clken_gen;
    localparam int NUM_CH = 3;
    localparam int ACC_W  = 8;

    logic                    refclk = 1'b0;
    logic                    rst_n;
    logic                    pll_locked;
    logic [NUM_CH*ACC_W-1:0] ch_inc;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       clken;
    logic                    sys_rst_n;
    logic                    running;
    logic                    lock_lost;

    int checks = 0;
    int errors = 0;

    pll_clken_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(8), .RST_HOLD(4)) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .ch_inc     (ch_inc),
        .ch_en      (ch_en),
        .clken      (clken),
        .sys_rst_n  (sys_rst_n),
        .running    (running),
        .lock_lost  (lock_lost)
    );

    always #5 refclk = ~refclk;

    // rate vectors: count pulses over n RUN edges starting from phase 0,
    // expected count = floor(n*inc/256) for enabled channels
    typedef struct {
        logic [7:0] inc0, inc1, inc2;
        logic [2:0] en;
        int         n;
        int         exp0, exp1, exp2;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // reset with pll_locked high, release between edges, expect release on
    // edge 2+1+8+4 = 15
    task automatic goto_run(input string tag);
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (14) tick();
        chk({tag, "_rst_edge14"}, {31'd0, sys_rst_n}, 0);
        chk({tag, "_run_edge14"}, {31'd0, running}, 0);
        tick();
        chk({tag, "_rst_edge15"}, {31'd0, sys_rst_n}, 1);
        chk({tag, "_run_edge15"}, {31'd0, running}, 1);
    endtask

    initial begin
        int cnt[3];

        vecs[0] = '{inc0: 8'd64,  inc1: 8'd1,   inc2: 8'd255, en: 3'b111, n: 256,  exp0: 64, exp1: 1,   exp2: 255};
        vecs[1] = '{inc0: 8'd0,   inc1: 8'd128, inc2: 8'd3,   en: 3'b111, n: 1000, exp0: 0,  exp1: 500, exp2: 11};
        vecs[2] = '{inc0: 8'd64,  inc1: 8'd64,  inc2: 8'd64,  en: 3'b101, n: 100,  exp0: 25, exp1: 0,   exp2: 25};
        vecs[3] = '{inc0: 8'd255, inc1: 8'd0,   inc2: 8'd200, en: 3'b111, n: 10,   exp0: 9,  exp1: 0,   exp2: 7};

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        ch_inc     = '0;
        ch_en      = '0;
        repeat (3) tick();
        chk("reset_clken", {29'd0, clken}, 0);
        chk("reset_sys_rst_n", {31'd0, sys_rst_n}, 0);
        chk("reset_running", {31'd0, running}, 0);
        chk("reset_lock_lost", {31'd0, lock_lost}, 0);

        // no lock: nothing should release
        rst_n = 1'b1;
        repeat (20) tick();
        chk("nolock_sys_rst_n", {31'd0, sys_rst_n}, 0);

        // power-up plus first clken0 pulse after the 4th RUN edge
        ch_inc = {8'd255, 8'd1, 8'd64};
        ch_en  = 3'b111;
        goto_run("s1");
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("s3_clken0_early", {31'd0, clken[0]}, 0);
        end
        tick();
        chk("s3_clken0_first", {31'd0, clken[0]}, 1);

        // lock glitch in SETTLE: drops seen at edges 7..9, relock restarts count
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        repeat (5) tick();
        chk("s2_rst_orig_release", {31'd0, sys_rst_n}, 0);
        repeat (9) tick();
        chk("s2_rst_edge23", {31'd0, sys_rst_n}, 0);
        tick();
        chk("s2_rst_edge24", {31'd0, sys_rst_n}, 1);

        // lock loss in RUN
        ch_inc = {8'd255, 8'd255, 8'd255};
        ch_en  = 3'b111;
        goto_run("s4");
        chk("s4_lock_lost_run", {31'd0, lock_lost}, 0);
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        chk("s4_run_l1", {31'd0, running}, 1);
        tick();
        chk("s4_run_l2", {31'd0, running}, 1);
        tick();
        chk("s4_clken_l3", {29'd0, clken}, 0);
        chk("s4_rst_l3", {31'd0, sys_rst_n}, 0);
        chk("s4_run_l3", {31'd0, running}, 0);
        chk("s4_lost_l3", {31'd0, lock_lost}, 1);
        pll_locked = 1'b1;
        repeat (14) tick();
        chk("s4_relock_rst14", {31'd0, sys_rst_n}, 0);
        tick();
        chk("s4_relock_rst15", {31'd0, sys_rst_n}, 1);
        chk("s4_relock_lost", {31'd0, lock_lost}, 1);

        // async reset mid-RUN, no clock edge in between
        repeat (3) tick();
        chk("s6_clken_pre", {29'd0, clken}, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_clken", {29'd0, clken}, 0);
        chk("s6_async_rst", {31'd0, sys_rst_n}, 0);
        chk("s6_async_run", {31'd0, running}, 0);
        chk("s6_async_lost", {31'd0, lock_lost}, 0);
        goto_run("s6");

        // ch_en toggle at acc0=128, inc0=64
        ch_inc = {8'd0, 8'd0, 8'd64};
        ch_en  = 3'b001;
        goto_run("s5");
        tick();
        tick();
        chk("s5_pre_clken0", {31'd0, clken[0]}, 0);
        ch_en  = 3'b000;
        cnt[0] = 0;
        repeat (10) begin
            tick();
            cnt[0] += int'(clken[0]);
        end
        chk("s5_disabled_pulses", cnt[0], 0);
        ch_en = 3'b001;
        tick();
        chk("s5_reen_edge1", {31'd0, clken[0]}, 0);
        tick();
        chk("s5_reen_edge2", {31'd0, clken[0]}, 1);

        // rate table
        foreach (vecs[v]) begin
            ch_inc = {vecs[v].inc2, vecs[v].inc1, vecs[v].inc0};
            ch_en  = vecs[v].en;
            goto_run($sformatf("v%0d", v));
            cnt = '{0, 0, 0};
            repeat (vecs[v].n) begin
                tick();
                for (int c = 0; c < 3; c++) cnt[c] += int'(clken[c]);
            end
            chk($sformatf("v%0d_ch0_pulses", v), cnt[0], vecs[v].exp0);
            chk($sformatf("v%0d_ch1_pulses", v), cnt[1], vecs[v].exp1);
            chk($sformatf("v%0d_ch2_pulses", v), cnt[2], vecs[v].exp2);
            chk($sformatf("v%0d_still_running", v), {31'd0, running}, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
